// File: rtl/i2c_byte_transmitter.sv
// I2C byte transmitter: shifts one DATA_W-bit word onto SDA MSB first, one bit per SCL
// rising edge, then releases SDA for the ACK slot and reports the slave's ACK/NACK.
module i2c_byte_transmitter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              scl_in,
  input  logic              rst,
  input  logic              enable,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              sda_in,
  output logic              sda_out,
  output logic              sda_oe,
  output logic              busy,
  output logic              done,
  output logic              ack
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StAck} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              sda_out_q, sda_out_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_q, ack_d;

  assign tx_ready = (state_q == StIdle) && enable && !rst;

  // Next-state logic: accept, serialise, release for ACK, capture ACK, abort on !enable.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    sda_out_d = sda_out_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_d     = ack_q;
    unique case (state_q)
      StIdle: begin
        sda_out_d = 1'b1;
        sda_oe_d  = 1'b0;
        busy_d    = 1'b0;
        if (tx_valid && tx_ready) begin
          shreg_d   = tx_data;
          sda_out_d = tx_data[DATA_W-1];
          sda_oe_d  = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = CntW'(DATA_W - 1);
          state_d   = StShift;
        end
      end
      StShift: begin
        if (!enable) begin
          sda_out_d = 1'b1;
          sda_oe_d  = 1'b0;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end else if (cnt_q != '0) begin
          // The bit on SDA is shreg_q[DATA_W-1]; the next one sits just below it.
          sda_out_d = shreg_q[DATA_W-2];
          shreg_d   = shreg_q << 1;
          cnt_d     = cnt_q - CntW'(1);
        end else begin
          // Last bit has been on SDA for a full cycle: hand the line to the slave.
          sda_out_d = 1'b1;
          sda_oe_d  = 1'b0;
          state_d   = StAck;
        end
      end
      StAck: begin
        sda_out_d = 1'b1;
        sda_oe_d  = 1'b0;
        busy_d    = 1'b0;
        state_d   = StIdle;
        if (enable) begin
          ack_d  = ~sda_in;
          done_d = 1'b1;
        end
      end
      default: begin
        sda_out_d = 1'b1;
        sda_oe_d  = 1'b0;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  // State register with synchronous reset that overrides everything.
  always_ff @(posedge scl_in) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      sda_out_q <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      sda_out_q <= sda_out_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
    end
  end

  assign sda_out = sda_out_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack     = ack_q;

endmodule

// File: tb/tb_i2c_byte_transmitter.sv
// Directed bench for i2c_byte_transmitter with hand-computed serial streams.
module tb_i2c_byte_transmitter;

  logic       scl_in = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       sda_in = 1'b1;
  logic       sda_out, sda_oe, busy, done, ack;

  int vectors = 0;
  int errors  = 0;

  i2c_byte_transmitter #(.DATA_W(8)) dut (
    .scl_in  (scl_in),
    .rst     (rst),
    .enable  (enable),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .sda_in  (sda_in),
    .sda_out (sda_out),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .done    (done),
    .ack     (ack)
  );

  always #5 scl_in = ~scl_in;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge scl_in);
    #1;
  endtask

  // Sends one byte from edge k through the done edge k+9, checking every cycle.
  // scramble: wiggle tx_data/tx_valid during SHIFT. nv/nd: inputs driven before edge k+9.
  task automatic run_byte(input logic [7:0] d, input logic slave_sda, input bit scramble,
                          input logic nv, input logic [7:0] nd, input string tag);
    vectors++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_pre: got %b want 1", tag, tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    vectors++;
    if ({sda_out, sda_oe, busy, tx_ready} !== {d[7], 3'b110}) begin
      errors++;
      $display("FAIL %s accept: got out/oe/busy/rdy=%b%b%b%b want %b110", tag, sda_out, sda_oe,
               busy, tx_ready, d[7]);
    end
    tx_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      if (scramble) begin
        tx_data  = 8'h00;
        tx_valid = i[0];
      end
      tick();
      vectors++;
      if ({sda_out, sda_oe, busy, done} !== {d[7-i], 3'b110}) begin
        errors++;
        $display("FAIL %s bit%0d: got out/oe/busy/done=%b%b%b%b want %b110", tag, 7 - i, sda_out,
                 sda_oe, busy, done, d[7-i]);
      end
    end
    tx_valid = 1'b0;
    tick();
    vectors++;
    if ({sda_out, sda_oe, busy, done} !== 4'b1010) begin
      errors++;
      $display("FAIL %s release: got out/oe/busy/done=%b%b%b%b want 1010", tag, sda_out, sda_oe,
               busy, done);
    end
    sda_in   = slave_sda;
    tx_valid = nv;
    tx_data  = nd;
    tick();
    sda_in = 1'b1;
    vectors++;
    if ({done, ack, busy, sda_oe, sda_out} !== {1'b1, ~slave_sda, 3'b001}) begin
      errors++;
      $display("FAIL %s done: got done/ack/busy/oe/out=%b%b%b%b%b want 1%b001", tag, done, ack,
               busy, sda_oe, sda_out, ~slave_sda);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({sda_out, sda_oe, busy, done, ack, tx_ready} !== 6'b100001) begin
      errors++;
      $display("FAIL reset: got out/oe/busy/done/ack/rdy=%b%b%b%b%b%b want 100001", sda_out,
               sda_oe, busy, done, ack, tx_ready);
    end
  endtask

  task automatic test_ack_a5();
    run_byte(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, "a5");
    tick();
    vectors++;
    if ({done, ack} !== 2'b01) begin
      errors++; $display("FAIL a5_after: got done/ack=%b%b want 01", done, ack);
    end
  endtask

  task automatic test_back_to_back();
    run_byte(8'h3C, 1'b1, 1'b0, 1'b1, 8'hFF, "3c_nack");
    vectors++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: got %b want 1", tx_ready);
    end
    tick();
    vectors++;
    if ({sda_out, sda_oe, busy, done, ack} !== 5'b11100) begin
      errors++;
      $display("FAIL b2b_accept: got out/oe/busy/done/ack=%b%b%b%b%b want 11100", sda_out,
               sda_oe, busy, done, ack);
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    sda_in = 1'b0;
    tick();
    tick();
    sda_in = 1'b1;
    vectors++;
    if ({done, ack} !== 2'b11) begin
      errors++; $display("FAIL b2b_ff_done: got done/ack=%b%b want 11", done, ack);
    end
    tick();
  endtask

  task automatic test_enable_abort();
    tx_data  = 8'h80;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if ({sda_out, sda_oe, busy} !== 3'b011) begin
      errors++;
      $display("FAIL abort_pre: got out/oe/busy=%b%b%b want 011", sda_out, sda_oe, busy);
    end
    enable = 1'b0;
    tick();
    vectors++;
    if ({sda_out, sda_oe, busy, done, ack, tx_ready} !== 6'b100010) begin
      errors++;
      $display("FAIL abort: got out/oe/busy/done/ack/rdy=%b%b%b%b%b%b want 100010", sda_out,
               sda_oe, busy, done, ack, tx_ready);
    end
    sda_in   = 1'b0;
    tx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if ({done, busy, sda_oe, ack} !== 4'b0001) begin
        errors++;
        $display("FAIL abort_hold%0d: got done/busy/oe/ack=%b%b%b%b want 0001", i, done, busy,
                 sda_oe, ack);
      end
    end
    tx_valid = 1'b0;
    sda_in   = 1'b1;
    enable   = 1'b1;
    #1;
  endtask

  task automatic test_reset_mid_byte();
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if ({sda_out, sda_oe, busy, done, ack, tx_ready} !== 6'b100000) begin
      errors++;
      $display("FAIL rst_mid: got out/oe/busy/done/ack/rdy=%b%b%b%b%b%b want 100000", sda_out,
               sda_oe, busy, done, ack, tx_ready);
    end
    rst = 1'b0;
    #1;
    run_byte(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "00_after_rst");
    tick();
  endtask

  task automatic test_data_stable();
    run_byte(8'h55, 1'b1, 1'b1, 1'b0, 8'h00, "55_scramble");
    tick();
    vectors++;
    if ({done, busy, sda_oe, ack} !== 4'b0000) begin
      errors++;
      $display("FAIL 55_after: got done/busy/oe/ack=%b%b%b%b want 0000", done, busy, sda_oe, ack);
    end
  endtask

  initial begin
    test_reset();
    test_ack_a5();
    test_back_to_back();
    test_enable_abort();
    test_reset_mid_byte();
    test_data_stable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
